// File: rtl/music_pkg.sv
// Shared state types and constants for the music sequencer and its note divider.
package music_pkg;

  localparam int unsigned DEFAULT_CLK_HZ = 50_000_000;
  localparam int unsigned SILENCE_DIV    = 1;

  typedef enum logic {
    IDLE,
    PLAY
  } seq_state_e;

  typedef enum logic [1:0] {
    CTL_IDLE,
    CTL_LEFT,
    CTL_RIGHT
  } ctl_state_e;

  typedef enum logic {
    DIV_IDLE,
    DIV_RUN
  } div_state_e;

endpackage

// File: rtl/note_divider.sv
// Sequential restoring divider: NUMERATOR / den_i, one quotient bit per clock,
// MSB first. The start cycle already resolves the top quotient bit.
module note_divider
  import music_pkg::*;
#(
  parameter int unsigned NUM_W     = 26,
  parameter int unsigned DEN_W     = 32,
  parameter int unsigned NUMERATOR = DEFAULT_CLK_HZ
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [DEN_W-1:0] den_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [NUM_W-1:0] quo_o
);

  localparam int unsigned      CNT_W = (NUM_W > 2) ? $clog2(NUM_W) : 1;
  localparam logic [NUM_W-1:0] NUM   = NUM_W'(NUMERATOR);

  div_state_e       state_q, state_d;
  logic [DEN_W-1:0] den_q, den_d;
  logic [DEN_W:0]   rem_q, rem_d;
  logic [NUM_W-1:0] quo_q, quo_d;
  logic [CNT_W-1:0] bit_q, bit_d;
  logic             done_q, done_d;

  logic [DEN_W-1:0] stepDen;
  logic [DEN_W:0]   stepRem;
  logic             stepBit;
  logic [DEN_W:0]   shifted;
  logic [DEN_W:0]   trial;
  logic             fits;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= DIV_IDLE;
      den_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      bit_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      den_q   <= den_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      bit_q   <= bit_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    den_d   = den_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    bit_d   = bit_q;
    done_d  = 1'b0;

    // Remainder stays below the divisor, so its top bit can be dropped before shifting.
    if (state_q == DIV_IDLE) begin
      stepDen = den_i;
      stepRem = '0;
      stepBit = NUM[NUM_W-1];
    end else begin
      stepDen = den_q;
      stepRem = rem_q;
      stepBit = NUM[bit_q];
    end
    shifted = {stepRem[DEN_W-1:0], stepBit};
    fits    = (shifted >= {1'b0, stepDen});
    trial   = fits ? (shifted - {1'b0, stepDen}) : shifted;

    if (state_q == DIV_IDLE) begin
      if (start_i) begin
        den_d   = den_i;
        rem_d   = trial;
        quo_d   = NUM_W'(fits);
        bit_d   = CNT_W'(NUM_W - 2);
        state_d = DIV_RUN;
      end
    end else begin
      rem_d = trial;
      quo_d = {quo_q[NUM_W-2:0], fits};
      if (bit_q == '0) begin
        state_d = DIV_IDLE;
        done_d  = 1'b1;
      end else begin
        bit_d = bit_q - 1'b1;
      end
    end
  end

  assign busy_o = (state_q == DIV_RUN);
  assign done_o = done_q;
  assign quo_o  = quo_q;

endmodule

// File: rtl/music_sequencer.sv
// Song sequencer: per-slot tempo/length playback FSM plus note-divider control
// that turns the current left/right tones into CLK_HZ/tone divider values.
module music_sequencer
  import music_pkg::*;
#(
  parameter int unsigned N_SONGS = 9,
  parameter int unsigned BEAT_W  = 12,
  parameter int unsigned TEMPO_W = 25,
  parameter int unsigned FREQ_W  = 32,
  parameter int unsigned DIV_W   = 22,
  parameter int unsigned CLK_HZ  = DEFAULT_CLK_HZ
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_SONGS-1:0]           play_req,
  input  logic [N_SONGS*BEAT_W-1:0]    song_len,
  input  logic [N_SONGS*TEMPO_W-1:0]   tempo,
  input  logic [N_SONGS-1:0]           loop_en,
  input  logic                         pause,
  input  logic [FREQ_W-1:0]            tone_l,
  input  logic [FREQ_W-1:0]            tone_r,
  output logic [BEAT_W-1:0]            beat,
  output logic [$clog2(N_SONGS)-1:0]   song_sel,
  output logic                         active,
  output logic                         song_done,
  output logic [DIV_W-1:0]             note_div_l,
  output logic [DIV_W-1:0]             note_div_r,
  output logic                         div_valid
);

  localparam int unsigned SEL_W = $clog2(N_SONGS);
  localparam int unsigned NUM_W = $clog2(CLK_HZ + 1);
  localparam logic [DIV_W-1:0] SILENCE = DIV_W'(SILENCE_DIV);

  seq_state_e         seqState_q, seqState_d;
  logic [SEL_W-1:0]   songSel_q, songSel_d;
  logic [BEAT_W-1:0]  beat_q, beat_d;
  logic [TEMPO_W-1:0] tempoCnt_q, tempoCnt_d;
  logic               songDone_q, songDone_d;

  logic               reqHit;
  logic [SEL_W-1:0]   reqIdx;
  logic [BEAT_W-1:0]  curLen, lastBeat;
  logic [TEMPO_W-1:0] curTempo, lastCount;
  logic               beatTick;

  ctl_state_e         ctl_q, ctl_d;
  logic [FREQ_W-1:0]  toneL_q, toneR_q;
  logic [FREQ_W-1:0]  opL_q, opL_d, opR_q, opR_d;
  logic [FREQ_W-1:0]  lastL_q, lastL_d, lastR_q, lastR_d;
  logic [DIV_W-1:0]   resL_q, resL_d;
  logic [DIV_W-1:0]   noteL_q, noteL_d, noteR_q, noteR_d;
  logic [FREQ_W-1:0]  effL, effR;
  logic               tonesChanged;

  logic               divStart;
  logic [FREQ_W-1:0]  divDen;
  logic               divBusy;
  logic               divDone;
  logic [NUM_W-1:0]   divQuo;
  logic [DIV_W-1:0]   satQuo;

  function automatic logic [DIV_W-1:0] saturate(input logic [NUM_W-1:0] q);
    logic [NUM_W+DIV_W-1:0] wide;
    wide = {{DIV_W{1'b0}}, q};
    if ((wide >> DIV_W) != '0) return '1;
    return wide[DIV_W-1:0];
  endfunction

  // Lowest-numbered request wins when several slots ask at once.
  always_comb begin
    reqHit = 1'b0;
    reqIdx = '0;
    for (int i = N_SONGS - 1; i >= 0; i--) begin
      if (play_req[i]) begin
        reqHit = 1'b1;
        reqIdx = SEL_W'(i);
      end
    end
  end

  assign curLen    = song_len[songSel_q*BEAT_W +: BEAT_W];
  assign curTempo  = tempo[songSel_q*TEMPO_W +: TEMPO_W];
  assign lastBeat  = (curLen == '0) ? '0 : curLen - 1'b1;
  assign lastCount = (curTempo == '0) ? '0 : curTempo - 1'b1;
  assign beatTick  = (tempoCnt_q >= lastCount);

  always_ff @(posedge clk) begin
    if (!rst) begin
      seqState_q <= IDLE;
      songSel_q  <= '0;
      beat_q     <= '0;
      tempoCnt_q <= '0;
      songDone_q <= 1'b0;
    end else begin
      seqState_q <= seqState_d;
      songSel_q  <= songSel_d;
      beat_q     <= beat_d;
      tempoCnt_q <= tempoCnt_d;
      songDone_q <= songDone_d;
    end
  end

  always_comb begin
    seqState_d = seqState_q;
    songSel_d  = songSel_q;
    beat_d     = beat_q;
    tempoCnt_d = tempoCnt_q;
    songDone_d = 1'b0;

    case (seqState_q)
      IDLE: begin
        if (reqHit) begin
          seqState_d = PLAY;
          songSel_d  = reqIdx;
          beat_d     = '0;
          tempoCnt_d = '0;
        end
      end
      PLAY: begin
        // A request always beats a same-cycle end of song, so no done pulse then.
        if (reqHit) begin
          beat_d     = '0;
          tempoCnt_d = '0;
          if (reqIdx == songSel_q) seqState_d = IDLE;
          else songSel_d = reqIdx;
        end else if (!pause) begin
          if (beatTick) begin
            tempoCnt_d = '0;
            if (beat_q >= lastBeat) begin
              beat_d = '0;
              if (!loop_en[songSel_q]) begin
                seqState_d = IDLE;
                songDone_d = 1'b1;
              end
            end else begin
              beat_d = beat_q + 1'b1;
            end
          end else begin
            tempoCnt_d = tempoCnt_q + 1'b1;
          end
        end
      end
      default: seqState_d = IDLE;
    endcase
  end

  assign beat      = beat_q;
  assign song_sel  = songSel_q;
  assign active    = (seqState_q == PLAY);
  assign song_done = songDone_q;

  // Silence (idle or zero tone) is tracked as tone 0 and never sent to the divider.
  assign effL         = active ? toneL_q : '0;
  assign effR         = active ? toneR_q : '0;
  assign tonesChanged = (effL != lastL_q) || (effR != lastR_q);
  assign satQuo       = saturate(divQuo);

  always_ff @(posedge clk) begin
    if (!rst) begin
      ctl_q   <= CTL_IDLE;
      toneL_q <= '0;
      toneR_q <= '0;
      opL_q   <= '0;
      opR_q   <= '0;
      lastL_q <= '0;
      lastR_q <= '0;
      resL_q  <= SILENCE;
      noteL_q <= SILENCE;
      noteR_q <= SILENCE;
    end else begin
      ctl_q   <= ctl_d;
      toneL_q <= tone_l;
      toneR_q <= tone_r;
      opL_q   <= opL_d;
      opR_q   <= opR_d;
      lastL_q <= lastL_d;
      lastR_q <= lastR_d;
      resL_q  <= resL_d;
      noteL_q <= noteL_d;
      noteR_q <= noteR_d;
    end
  end

  // Results only reach the outputs together, when the right side finishes.
  always_comb begin
    ctl_d    = ctl_q;
    opL_d    = opL_q;
    opR_d    = opR_q;
    lastL_d  = lastL_q;
    lastR_d  = lastR_q;
    resL_d   = resL_q;
    noteL_d  = noteL_q;
    noteR_d  = noteR_q;
    divStart = 1'b0;
    divDen   = '0;

    case (ctl_q)
      CTL_IDLE: begin
        if (tonesChanged && !divBusy) begin
          opL_d = effL;
          opR_d = effR;
          if (effL != '0) begin
            divStart = 1'b1;
            divDen   = effL;
            ctl_d    = CTL_LEFT;
          end else begin
            resL_d = SILENCE;
            if (effR != '0) begin
              divStart = 1'b1;
              divDen   = effR;
              ctl_d    = CTL_RIGHT;
            end else begin
              noteL_d = SILENCE;
              noteR_d = SILENCE;
              lastL_d = effL;
              lastR_d = effR;
            end
          end
        end
      end
      CTL_LEFT: begin
        if (divDone) begin
          resL_d = satQuo;
          if (opR_q != '0) begin
            divStart = 1'b1;
            divDen   = opR_q;
            ctl_d    = CTL_RIGHT;
          end else begin
            noteL_d = satQuo;
            noteR_d = SILENCE;
            lastL_d = opL_q;
            lastR_d = opR_q;
            ctl_d   = CTL_IDLE;
          end
        end
      end
      CTL_RIGHT: begin
        if (divDone) begin
          noteL_d = resL_q;
          noteR_d = satQuo;
          lastL_d = opL_q;
          lastR_d = opR_q;
          ctl_d   = CTL_IDLE;
        end
      end
      default: ctl_d = CTL_IDLE;
    endcase
  end

  note_divider #(
    .NUM_W    (NUM_W),
    .DEN_W    (FREQ_W),
    .NUMERATOR(CLK_HZ)
  ) u_divider (
    .clk    (clk),
    .rst    (rst),
    .start_i(divStart),
    .den_i  (divDen),
    .busy_o (divBusy),
    .done_o (divDone),
    .quo_o  (divQuo)
  );

  assign note_div_l = noteL_q;
  assign note_div_r = noteR_q;
  assign div_valid  = (ctl_q == CTL_IDLE) && !tonesChanged;

endmodule

// File: tb/tb_music_sequencer.sv
// Randomized self-checking bench for music_sequencer against a beat/phase-level
// playback model and an arithmetic CLK_HZ/tone divider model.
module tb_music_sequencer;

  localparam int N   = 9;
  localparam int BW  = 12;
  localparam int TW  = 25;
  localparam int FW  = 32;
  localparam int DW  = 22;
  localparam longint CLK = 50_000_000;
  localparam longint SAT = (longint'(1) << DW) - 1;
  localparam int LAT_MAX = 2 * (26 + 1) + 2;

  logic              clk;
  logic              rst;
  logic [N-1:0]      play_req;
  logic [N*BW-1:0]   songLenBus;
  logic [N*TW-1:0]   tempoBus;
  logic [N-1:0]      loopBus;
  logic              pause;
  logic [FW-1:0]     tone_l, tone_r;
  logic [BW-1:0]     beat;
  logic [3:0]        song_sel;
  logic              active, song_done;
  logic [DW-1:0]     note_div_l, note_div_r;
  logic              div_valid;

  int compareCount = 0;
  int mismatchCount = 0;

  bit     mPlaying;
  int     mSel, mBeat, mPhase;
  bit     mDone;
  longint mToneL, mToneR;

  music_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .play_req  (play_req),
    .song_len  (songLenBus),
    .tempo     (tempoBus),
    .loop_en   (loopBus),
    .pause     (pause),
    .tone_l    (tone_l),
    .tone_r    (tone_r),
    .beat      (beat),
    .song_sel  (song_sel),
    .active    (active),
    .song_done (song_done),
    .note_div_l(note_div_l),
    .note_div_r(note_div_r),
    .div_valid (div_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: observed %0d expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic longint expDiv(input longint t);
    longint q;
    if (t == 0) return 1;
    q = CLK / t;
    if (q > SAT) return SAT;
    return q;
  endfunction

  function automatic logic [FW-1:0] randTone();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return 32'd1;
      2: return 32'd440;
      3: return FW'($urandom_range(20, 20000));
      4: return FW'($urandom);
      default: return FW'($urandom_range(2, 100));
    endcase
  endfunction

  task automatic setSlot(input int s, input int t, input int l, input int lp);
    tempoBus[s*TW +: TW]   = TW'(t);
    songLenBus[s*BW +: BW] = BW'(l);
    loopBus[s]             = (lp != 0);
  endtask

  // Model advances on the inputs present just before the clock edge.
  task automatic modelStep();
    int low;
    int tVal, lVal;
    mDone = 0;
    if (!rst) begin
      mPlaying = 0; mSel = 0; mBeat = 0; mPhase = 0; mToneL = 0; mToneR = 0;
      return;
    end
    mToneL = tone_l;
    mToneR = tone_r;
    low = -1;
    for (int i = N - 1; i >= 0; i--) if (play_req[i]) low = i;
    if (low >= 0) begin
      if (mPlaying && low == mSel) begin
        mPlaying = 0; mBeat = 0;
      end else begin
        mPlaying = 1; mSel = low; mBeat = 0; mPhase = 0;
      end
    end else if (mPlaying && !pause) begin
      tVal = int'(tempoBus[mSel*TW +: TW]);
      lVal = int'(songLenBus[mSel*BW +: BW]);
      if (tVal == 0) tVal = 1;
      if (lVal == 0) lVal = 1;
      mPhase++;
      if (mPhase >= tVal) begin
        mPhase = 0;
        mBeat++;
        if (mBeat >= lVal) begin
          mBeat = 0;
          if (!loopBus[mSel]) begin
            mPlaying = 0;
            mDone = 1;
          end
        end
      end
    end
  endtask

  // One clock: update model, clock the DUT, compare everything observable.
  task automatic stepClock();
    modelStep();
    @(posedge clk);
    #1;
    play_req = '0;
    checkOutput("beat", beat, mBeat);
    checkOutput("songSel", song_sel, mSel);
    checkOutput("active", active, mPlaying);
    checkOutput("songDone", song_done, mDone);
    if (div_valid) begin
      checkOutput("divL", note_div_l, expDiv(mPlaying ? mToneL : 0));
      checkOutput("divR", note_div_r, expDiv(mPlaying ? mToneR : 0));
    end
  endtask

  task automatic waitValid(input string tag);
    int n;
    n = 0;
    do begin
      stepClock();
      n++;
    end while (!div_valid && n < LAT_MAX + 4);
    checkOutput(tag, (n <= LAT_MAX), 1);
  endtask

  task automatic applyStimulus();
    int r;
    rst = ($urandom_range(0, 799) != 0);
    if (!mPlaying && $urandom_range(0, 9) == 0)
      setSlot($urandom_range(0, 8), $urandom_range(0, 6), $urandom_range(0, 5), $urandom_range(0, 1));
    if ($urandom_range(0, 29) == 0) pause = ~pause;
    if ($urandom_range(0, 199) == 0) begin
      tone_l = randTone();
      tone_r = randTone();
    end
    r = $urandom_range(0, 59);
    if (r == 0) play_req[$urandom_range(0, 8)] = 1'b1;
    else if (r == 1) play_req = N'($urandom_range(1, 511));
    stepClock();
  endtask

  initial begin
    int beatBefore;
    int guard;
    rst = 1'b0; play_req = '0; pause = 1'b0; tone_l = '0; tone_r = '0;
    songLenBus = '0; tempoBus = '0; loopBus = '0;
    for (int s = 0; s < N; s++) setSlot(s, 3, 2, 0);
    setSlot(2, 4, 3, 0);
    setSlot(5, 7, 4, 1);

    // Reset values
    stepClock();
    stepClock();
    checkOutput("rstValid", div_valid, 1);
    checkOutput("rstDivL", note_div_l, 1);
    rst = 1'b1;
    stepClock();

    // Slot 2: tempo 4, length 3, no loop
    play_req[2] = 1'b1;
    stepClock();
    for (int k = 1; k <= 12; k++) begin
      stepClock();
      if (k < 12) begin
        checkOutput("seqBeat", beat, k / 4);
        checkOutput("seqNoDone", song_done, 0);
      end
    end
    checkOutput("doneAt12", song_done, 1);
    checkOutput("activeFell", active, 0);
    stepClock();
    checkOutput("donePulse", song_done, 0);

    // Lowest index wins, then preemption
    play_req = 9'b000010100;
    stepClock();
    checkOutput("lowestSel", song_sel, 2);
    stepClock();
    stepClock();
    play_req[5] = 1'b1;
    stepClock();
    checkOutput("preemptSel", song_sel, 5);
    checkOutput("preemptBeat", beat, 0);

    // Divider values while playing
    tone_l = 32'd440; tone_r = '0;
    waitValid("lat440");
    checkOutput("div440", note_div_l, 113636);
    checkOutput("divZeroR", note_div_r, 1);
    tone_l = 32'd1;
    waitValid("latSat");
    checkOutput("divSat", note_div_l, 4194303);
    tone_l = 32'd523; tone_r = 32'd659;
    waitValid("latBoth");
    checkOutput("div523", note_div_l, 95602);
    checkOutput("div659", note_div_r, 75872);

    // Pause mid-beat (slot 5 tempo 7)
    guard = 0;
    while (mPhase != 3 && guard < 20) begin
      stepClock();
      guard++;
    end
    checkOutput("pausePhase", mPhase, 3);
    beatBefore = beat;
    pause = 1'b1;
    for (int k = 0; k < 10; k++) stepClock();
    checkOutput("pauseBeat", beat, beatBefore);
    pause = 1'b0;
    for (int k = 0; k < 3; k++) stepClock();
    checkOutput("resumeHold", beat, beatBefore);
    stepClock();
    checkOutput("resumeBeat", beat, (beatBefore + 1) % 4);

    // Reset mid-song and mid-division
    tone_l = 32'd1000; tone_r = 32'd3000;
    for (int k = 0; k < 10; k++) stepClock();
    rst = 1'b0;
    stepClock();
    checkOutput("abortBeat", beat, 0);
    checkOutput("abortSel", song_sel, 0);
    checkOutput("abortActive", active, 0);
    checkOutput("abortDone", song_done, 0);
    checkOutput("abortDivL", note_div_l, 1);
    checkOutput("abortDivR", note_div_r, 1);
    checkOutput("abortValid", div_valid, 1);
    rst = 1'b1;
    stepClock();

    // Randomized traffic against the model
    for (int c = 0; c < 4000; c++) applyStimulus();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
